// File: rtl/mul_hilo_unit_if.sv
// CPU-side request/result bundle for the HI/LO multiply controller.
// The CPU drives requests as master; the controller answers as slave.
interface mul_hilo_unit_if;
  logic        start;
  logic        op_signed;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cancel;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op_signed, a_in, b_in, cancel, mthi, mtlo, hi_wdata, lo_wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_signed, a_in, b_in, cancel, mthi, mtlo, hi_wdata, lo_wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_hilo_unit.sv
// Issue/writeback controller for the pipelined 32x32 signed multiplier.
// Holds the operands stable for the full multiplier latency, then writes the
// (optionally unsigned-corrected) product into HI/LO and pulses done.
//
// state | meaning
// IDLE  | no multiply in flight; accepts start, mthi, mtlo
// WAIT  | operands held on mul_a/mul_b, counting the multiplier latency
module mul_hilo_unit #(
  parameter int MUL_LAT = 7,
  parameter int CNT_W   = 4   // 2**CNT_W must exceed MUL_LAT
) (
  input  logic               clk,
  input  logic               reset,
  mul_hilo_unit_if.slave     cpu,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [63:0]        mul_z
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_signed_q;
  logic [63:0]      product;

  // Signed product from MUL, plus the two-term fixup that turns it into the
  // unsigned product when the captured op was MULTU (all mod 2^64).
  always_comb begin
    product = mul_z;
    if (!op_signed_q) begin
      if (mul_a[31]) product = product + {mul_b, 32'b0};
      if (mul_b[31]) product = product + {mul_a, 32'b0};
    end
  end

  // Controller FSM with registered outputs: operand issue, latency count,
  // HI/LO writeback, cancel and direct HI/LO moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_signed_q <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      cpu.busy    <= 1'b0;
      cpu.done    <= 1'b0;
      cpu.hi      <= '0;
      cpu.lo      <= '0;
    end else begin
      cpu.done <= 1'b0;
      case (state)
        IDLE: begin
          // Moves land on this edge even if a start is accepted alongside;
          // the product will overwrite them at writeback.
          if (cpu.mthi) cpu.hi <= cpu.hi_wdata;
          if (cpu.mtlo) cpu.lo <= cpu.lo_wdata;
          // A simultaneous cancel drops the start.
          if (cpu.start && !cpu.cancel) begin
            mul_a       <= cpu.a_in;
            mul_b       <= cpu.b_in;
            op_signed_q <= cpu.op_signed;
            cnt         <= '0;
            cpu.busy    <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cpu.cancel) begin
            // Leftover MUL pipeline data is harmless: every new op waits the
            // full latency before capture.
            cnt      <= '0;
            cpu.busy <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CNT_LAST) begin
            cpu.hi   <= product[63:32];
            cpu.lo   <= product[31:0];
            cpu.done <= 1'b1;
            cpu.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt      <= '0;
          cpu.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit with a 7-stage signed multiplier model.
module tb_mul_hilo_unit;
  localparam int MUL_LAT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_z;
  logic [63:0] pipe [MUL_LAT];

  int checks = 0;
  int errors = 0;

  mul_hilo_unit_if cpu ();

  mul_hilo_unit #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (cpu),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_z (mul_z)
  );

  always #5 clk = ~clk;

  // Multiplier model: signed product appears MUL_LAT edges after operands.
  always @(posedge clk) begin
    logic signed [63:0] sa, sb;
    sa = {{32{mul_a[31]}}, mul_a};
    sb = {{32{mul_b[31]}}, mul_b};
    pipe[0] <= sa * sb;
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_z = pipe[MUL_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    // Only used for inline-style reporting consistency; comparisons are done by callers.
  endtask

  // Full multiply: start before E0, expect busy for 8 cycles, done at E8.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
    int bad;
    bad = 0;
    cpu.start = 1'b1; cpu.a_in = a; cpu.b_in = b; cpu.op_signed = sgn;
    tick();
    cpu.start = 1'b0; cpu.a_in = 32'h0; cpu.b_in = 32'h0;
    checks++;
    if (mul_a !== a || mul_b !== b) begin
      errors++;
      $display("FAIL %s operands: got %h/%h want %h/%h", nm, mul_a, mul_b, a, b);
    end
    for (int k = 0; k <= MUL_LAT; k++) begin
      if (cpu.busy !== 1'b1 || cpu.done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s busy window: %0d bad cycles, want 0", nm, bad);
    end
    checks++;
    if (cpu.done !== 1'b1 || cpu.busy !== 1'b0 || cpu.hi !== eh || cpu.lo !== el) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b hi=%h lo=%h want done=1 busy=0 hi=%h lo=%h",
               nm, cpu.done, cpu.busy, cpu.hi, cpu.lo, eh, el);
    end
    tick();
    checks++;
    if (cpu.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse width: done=%b want 0", nm, cpu.done);
    end
  endtask

  task automatic test_reset();
    cpu.start = 0; cpu.op_signed = 0; cpu.a_in = 0; cpu.b_in = 0; cpu.cancel = 0;
    cpu.mthi = 0; cpu.mtlo = 0; cpu.hi_wdata = 0; cpu.lo_wdata = 0;
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (cpu.busy !== 0 || cpu.done !== 0 || cpu.hi !== 0 || cpu.lo !== 0 || mul_a !== 0 || mul_b !== 0) begin
      errors++;
      $display("FAIL reset state: busy=%b done=%b hi=%h lo=%h a=%h b=%h want all 0",
               cpu.busy, cpu.done, cpu.hi, cpu.lo, mul_a, mul_b);
    end
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_signed_unsigned();
    run_mul(32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7xm3");
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, "multu_ffxff");
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, "mult_ffxff");
    run_mul(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, "mult_8x8");
    run_mul(32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, "multu_8x8");
    run_mul(32'h80000000, 32'd3, 1'b0, 32'h00000001, 32'h80000000, "multu_8x3");
    run_mul(32'd3, 32'h80000000, 1'b1, 32'hFFFFFFFE, 32'h80000000, "mult_3x8");
  endtask

  task automatic test_start_while_busy();
    int dones;
    dones = 0;
    cpu.start = 1; cpu.a_in = 32'd7; cpu.b_in = 32'd3; cpu.op_signed = 1;
    tick();
    cpu.start = 0;
    tick(); tick();
    cpu.start = 1; cpu.a_in = 32'd5; cpu.b_in = 32'd9;
    tick();
    cpu.start = 0;
    checks++;
    if (mul_a !== 32'd7 || mul_b !== 32'd3) begin
      errors++;
      $display("FAIL busy_start operands: got %h/%h want 7/3", mul_a, mul_b);
    end
    for (int k = 0; k < 14; k++) begin
      if (cpu.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 1 || cpu.hi !== 32'd0 || cpu.lo !== 32'd21) begin
      errors++;
      $display("FAIL busy_start result: dones=%0d hi=%h lo=%h want 1 0 15", dones, cpu.hi, cpu.lo);
    end
  endtask

  task automatic test_cancel();
    int dones;
    // cancel at E3
    dones = 0;
    cpu.start = 1; cpu.a_in = 32'd100; cpu.b_in = 32'd100; cpu.op_signed = 1;
    tick();
    cpu.start = 0;
    tick(); tick();
    cpu.cancel = 1;
    tick();
    cpu.cancel = 0;
    checks++;
    if (cpu.busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_e3 busy: got %b want 0", cpu.busy);
    end
    for (int k = 0; k < 10; k++) begin
      if (cpu.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0 || cpu.hi !== 32'd0 || cpu.lo !== 32'd21) begin
      errors++;
      $display("FAIL cancel_e3 hilo: dones=%0d hi=%h lo=%h want 0 0 15", dones, cpu.hi, cpu.lo);
    end
    run_mul(32'd2, 32'd3, 1'b1, 32'd0, 32'd6, "after_cancel");

    // cancel together with start in IDLE drops the start
    cpu.start = 1; cpu.cancel = 1; cpu.a_in = 32'd9; cpu.b_in = 32'd9;
    tick();
    cpu.start = 0; cpu.cancel = 0;
    checks++;
    if (cpu.busy !== 1'b0 || mul_a !== 32'd2) begin
      errors++;
      $display("FAIL cancel_start_idle: busy=%b mul_a=%h want 0 2", cpu.busy, mul_a);
    end

    // cancel on the capture edge
    dones = 0;
    cpu.start = 1; cpu.a_in = 32'd11; cpu.b_in = 32'd11; cpu.op_signed = 1;
    tick();
    cpu.start = 0;
    for (int k = 0; k < MUL_LAT; k++) tick();
    cpu.cancel = 1;
    tick();
    cpu.cancel = 0;
    for (int k = 0; k < 4; k++) begin
      if (cpu.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0 || cpu.busy !== 1'b0 || cpu.lo !== 32'd6) begin
      errors++;
      $display("FAIL cancel_capture: dones=%0d busy=%b lo=%h want 0 0 6", dones, cpu.busy, cpu.lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    cpu.mthi = 1; cpu.mtlo = 1; cpu.hi_wdata = 32'h1234; cpu.lo_wdata = 32'h5678;
    tick();
    cpu.mthi = 0; cpu.mtlo = 0;
    checks++;
    if (cpu.hi !== 32'h1234 || cpu.lo !== 32'h5678) begin
      errors++;
      $display("FAIL mthi_mtlo idle: hi=%h lo=%h want 1234 5678", cpu.hi, cpu.lo);
    end
    // write while busy is ignored
    cpu.start = 1; cpu.a_in = 32'd4; cpu.b_in = 32'd5; cpu.op_signed = 0;
    tick();
    cpu.start = 0;
    cpu.mthi = 1; cpu.mtlo = 1; cpu.hi_wdata = 32'hDEAD; cpu.lo_wdata = 32'hBEEF;
    tick();
    cpu.mthi = 0; cpu.mtlo = 0;
    checks++;
    if (cpu.hi !== 32'h1234 || cpu.lo !== 32'h5678) begin
      errors++;
      $display("FAIL mthi_busy: hi=%h lo=%h want 1234 5678", cpu.hi, cpu.lo);
    end
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (cpu.busy !== 1'b0 || cpu.hi !== 32'd0 || cpu.lo !== 32'd20) begin
      errors++;
      $display("FAIL mthi_busy result: busy=%b hi=%h lo=%h want 0 0 14", cpu.busy, cpu.hi, cpu.lo);
    end
    // move together with start: move lands now, product later
    cpu.mthi = 1; cpu.hi_wdata = 32'hCAFE; cpu.start = 1; cpu.a_in = 32'd6; cpu.b_in = 32'd7;
    cpu.op_signed = 1;
    tick();
    cpu.mthi = 0; cpu.start = 0;
    checks++;
    if (cpu.hi !== 32'hCAFE || cpu.busy !== 1'b1) begin
      errors++;
      $display("FAIL mthi_start: hi=%h busy=%b want cafe 1", cpu.hi, cpu.busy);
    end
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (cpu.hi !== 32'd0 || cpu.lo !== 32'd42 || cpu.done !== 1'b1) begin
      errors++;
      $display("FAIL mthi_start result: hi=%h lo=%h done=%b want 0 2a 1", cpu.hi, cpu.lo, cpu.done);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int dones;
    dones = 0;
    cpu.start = 1; cpu.a_in = 32'd8; cpu.b_in = 32'd8; cpu.op_signed = 1;
    tick();
    cpu.start = 0;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (cpu.busy !== 0 || cpu.done !== 0 || cpu.hi !== 0 || cpu.lo !== 0 || mul_a !== 0 || mul_b !== 0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h a=%h b=%h want all 0",
               cpu.busy, cpu.done, cpu.hi, cpu.lo, mul_a, mul_b);
    end
    tick();
    #3 reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (cpu.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0 || cpu.busy !== 1'b0 || cpu.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op after: dones=%0d busy=%b lo=%h want 0 0 0", dones, cpu.busy, cpu.lo);
    end
    run_mul(32'hFFFFFFFE, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF6, "after_reset");
  endtask

  initial begin
    test_reset();
    test_signed_unsigned();
    test_start_while_busy();
    test_cancel();
    test_mthi_mtlo();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
